// File: rtl/i2c_cmd_sequencer_pkg.sv
// rtl/i2c_cmd_sequencer_pkg.sv - shared op encodings, FSM states, command record and byte mask for the I2C command sequencer
// Contents:
//   CMD_WRITE / CMD_READ   op[3:2] encodings shared with the I2C master
//   ST_*                   sequencer FSM state encodings
//   cmd_t                  44-bit queued command record {addr, op, data}
//   byte_mask()            keeps the low (n+1) bytes of a 32-bit word
package i2c_cmd_sequencer_pkg;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;

    localparam int CMD_W = 44;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_t;

    // nbytes_m1 is the byte count minus one, as carried in op[1:0].
    function automatic logic [31:0] byte_mask(input logic [1:0] nbytes_m1);
        logic [31:0] m;
        case (nbytes_m1)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            2'b10:   m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_fifo.sv
// rtl/i2c_cmd_sequencer_fifo.sv - synchronous command FIFO with occupancy count
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write strobe and word (ignored when full)
//   pop, pop_data       read strobe (ignored when empty) and head word (combinational)
//   full, empty, count  status derived from the occupancy register
module i2c_cmd_sequencer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues host commands and issues them one at a time to the I2C master
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o                command channel; cmd_addr_i, cmd_data_i, cmd_op_i
//   rsp_valid_o/rsp_ready_i                response channel; rsp_data_o (masked read data), rsp_error_o
//   fifo_cnt_o                             command FIFO occupancy
//   m_addr_o, m_data_o, m_cmd_o, m_sel_o   issue side to the master host interface
//   m_data_i, m_busy_i, m_error_i          status/result from the master
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter int          START_TIMEOUT = 4,
    parameter logic [23:0] XFER_TIMEOUT  = 24'hFFFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [7:0]             cmd_addr_i,
    input  logic [31:0]            cmd_data_i,
    input  logic [3:0]             cmd_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_error_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o,
    output logic [7:0]             m_addr_o,
    output logic [31:0]            m_data_o,
    output logic [3:0]             m_cmd_o,
    output logic                   m_sel_o,
    input  logic [31:0]            m_data_i,
    input  logic                   m_busy_i,
    input  logic                   m_error_i
);

    localparam int SW = $clog2(START_TIMEOUT + 1);

    cmd_t          push_cmd;
    cmd_t          head;
    logic [CMD_W-1:0] head_bits;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [2:0]    state;
    logic [SW-1:0] start_cnt;
    logic [23:0]   xfer_cnt;

    assign push_cmd    = '{addr: cmd_addr_i, op: cmd_op_i, data: cmd_data_i};
    assign head        = cmd_t'(head_bits);
    assign cmd_ready_o = ~fifo_full;

    // The m_busy_i check also keeps a transfer that survived a reset from
    // being interrupted by a fresh issue.
    assign pop = (state == ST_IDLE) & ~fifo_empty & ~rsp_valid_o & ~m_busy_i;

    i2c_cmd_sequencer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid_i),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            start_cnt   <= '0;
            xfer_cnt    <= '0;
            m_sel_o     <= 1'b0;
            m_addr_o    <= '0;
            m_data_o    <= '0;
            m_cmd_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            m_sel_o <= 1'b0;

            // The FSM only raises rsp_valid_o when the slot is already empty,
            // so this clear never collides with a new response.
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head.op[3]) begin
                            rsp_valid_o <= 1'b1;
                            rsp_error_o <= 1'b1;
                            rsp_data_o  <= '0;
                        end else begin
                            m_addr_o <= head.addr;
                            m_data_o <= head.data;
                            m_cmd_o  <= head.op;
                            // Registered here so the pulse lines up with ISSUE.
                            m_sel_o  <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    start_cnt <= '0;
                    xfer_cnt  <= '0;
                    state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (m_busy_i) begin
                        state <= ST_WAIT_DONE;
                    end else if (start_cnt == SW'(START_TIMEOUT)) begin
                        rsp_valid_o <= 1'b1;
                        rsp_error_o <= 1'b1;
                        rsp_data_o  <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!m_busy_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_error_o <= m_error_i;
                        if (!m_error_i && m_cmd_o[3:2] == CMD_READ) begin
                            rsp_data_o <= m_data_i & byte_mask(m_cmd_o[1:0]);
                        end else begin
                            rsp_data_o <= '0;
                        end
                        state <= ST_IDLE;
                    end else if (xfer_cnt == XFER_TIMEOUT) begin
                        rsp_valid_o <= 1'b1;
                        rsp_error_o <= 1'b1;
                        rsp_data_o  <= '0;
                        state       <= ST_DRAIN;
                    end else begin
                        xfer_cnt <= xfer_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The hung transfer already got its error response; whatever
                    // the master reports when it finally finishes is dropped.
                    if (!m_busy_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - directed self-checking bench for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [2:0]  fifo_cnt;
    logic [7:0]  m_addr;
    logic [31:0] m_data_out;
    logic [3:0]  m_cmd;
    logic        m_sel;
    logic [31:0] m_data_in;
    logic        m_busy;
    logic        m_err_in;
    logic        model_busy;
    logic        hold_busy;

    int          tests = 0;
    int          fails = 0;
    int          sel_cnt = 0;
    int          busy_len = 5;
    bit          ignore_sel = 1'b0;
    logic [31:0] rd_val = 32'h0;
    bit          err_val = 1'b0;

    always #5 clk = ~clk;

    assign m_busy = model_busy | hold_busy;

    i2c_cmd_sequencer #(
        .DEPTH         (4),
        .START_TIMEOUT (4),
        .XFER_TIMEOUT  (24'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .cmd_op_i    (cmd_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_error_o (rsp_error),
        .fifo_cnt_o  (fifo_cnt),
        .m_addr_o    (m_addr),
        .m_data_o    (m_data_out),
        .m_cmd_o     (m_cmd),
        .m_sel_o     (m_sel),
        .m_data_i    (m_data_in),
        .m_busy_i    (m_busy),
        .m_error_i   (m_err_in)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master model: busy rises one cycle after it sees sel, stays high for
    // busy_len cycles, then drops with rd_val/err_val presented.
    initial begin
        model_busy = 1'b0;
        m_data_in  = '0;
        m_err_in   = 1'b0;
        forever begin
            @(negedge clk);
            if (m_sel === 1'b1 && !ignore_sel) begin
                @(negedge clk);
                model_busy = 1'b1;
                m_data_in  = '0;
                m_err_in   = 1'b0;
                repeat (busy_len) @(negedge clk);
                m_data_in  = rd_val;
                m_err_in   = err_val;
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_sel === 1'b1) sel_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] a, input logic [3:0] op, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = op;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_wait_expired", 64'(n >= 500), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_sel(output int n);
        n = 0;
        while (m_sel !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle_bus();
        int n = 0;
        while (model_busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("bus_idle_wait_expired", 64'(n >= 1000), 0);
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp_data, input logic exp_err);
        int lat;
        wait_rsp(lat);
        check({tag, "_seen"}, 64'(lat < 1000), 1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_error, exp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int snap;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        hold_busy = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_m_sel", m_sel, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_data", m_data_out, 0);
        check("rst_m_cmd", m_cmd, 0);
        rst = 1'b0;

        // Write: data comes back as 0 even though the master drives something.
        busy_len = 50;
        rd_val   = 32'h1234_5678;
        push(8'h50, 4'b0011, 32'hA1B2_C3D4);
        get_rsp("write", 32'h0, 1'b0);
        check("write_sel_pulses", sel_cnt, 1);
        check("write_m_data", m_data_out, 32'hA1B2_C3D4);
        check("write_m_addr", m_addr, 8'h50);
        check("write_m_cmd", m_cmd, 4'b0011);

        // Reads with each byte count, then a NACKed read.
        busy_len = 5;
        rd_val   = 32'hDEAD_BEEF;
        push(8'h21, 4'b0101, 32'h0);
        get_rsp("read2", 32'h0000_BEEF, 1'b0);
        push(8'h21, 4'b0100, 32'h0);
        get_rsp("read1", 32'h0000_00EF, 1'b0);
        push(8'h21, 4'b0110, 32'h0);
        get_rsp("read3", 32'h00AD_BEEF, 1'b0);
        err_val = 1'b1;
        push(8'h21, 4'b0111, 32'h0);
        get_rsp("read_nack", 32'h0, 1'b1);
        err_val = 1'b0;

        // Fill the FIFO while the master looks busy.
        hold_busy = 1'b1;
        push(8'h31, 4'b0100, 32'h0);
        check("fill_cnt1", fifo_cnt, 1);
        push(8'h32, 4'b0101, 32'h0);
        check("fill_cnt2", fifo_cnt, 2);
        push(8'h33, 4'b0110, 32'h0);
        check("fill_cnt3", fifo_cnt, 3);
        push(8'h34, 4'b0111, 32'h0);
        check("fill_cnt4", fifo_cnt, 4);
        check("fill_ready_low", cmd_ready, 0);
        repeat (3) @(negedge clk);
        check("fill_held_cnt", fifo_cnt, 4);
        hold_busy = 1'b0;
        push(8'h35, 4'b0100, 32'h0);
        check("fill_cnt_after_pop", fifo_cnt, 4);
        check("fill_ready_low2", cmd_ready, 0);
        get_rsp("order1", 32'h0000_00EF, 1'b0);
        get_rsp("order2", 32'h0000_BEEF, 1'b0);
        get_rsp("order3", 32'h00AD_BEEF, 1'b0);
        get_rsp("order4", 32'hDEAD_BEEF, 1'b0);
        get_rsp("order5", 32'h0000_00EF, 1'b0);
        check("order_fifo_empty", fifo_cnt, 0);

        // Reserved ops are answered directly, never issued.
        snap = sel_cnt;
        push(8'h10, 4'b1000, 32'h5555_5555);
        wait_rsp(lat);
        check("reserved_latency_le2", 64'(lat <= 2), 1);
        get_rsp("reserved8", 32'h0, 1'b1);
        push(8'h10, 4'b1101, 32'h0);
        get_rsp("reservedD", 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        check("reserved_no_sel", sel_cnt, snap);

        // Lost start: sel seen, then ISSUE + (START_TIMEOUT+1) counting cycles.
        ignore_sel = 1'b1;
        push(8'h40, 4'b0000, 32'h1);
        wait_sel(n);
        check("start_sel_seen", 64'(n < 1000), 1);
        wait_rsp(lat);
        check("start_timeout_latency", lat, 6);
        get_rsp("start_timeout", 32'h0, 1'b1);
        ignore_sel = 1'b0;

        // Hung transfer: ISSUE + busy latency + XFER_TIMEOUT counts + register.
        busy_len = 300;
        push(8'h41, 4'b0111, 32'h0);
        wait_sel(n);
        check("xfer_sel_seen", 64'(n < 1000), 1);
        wait_rsp(lat);
        check("xfer_timeout_latency", lat, 103);
        get_rsp("xfer_timeout", 32'h0, 1'b1);
        busy_len = 5;
        snap = sel_cnt;
        push(8'h42, 4'b0000, 32'h2);
        repeat (20) @(negedge clk);
        check("drain_no_sel", sel_cnt, snap);
        check("drain_no_second_rsp", rsp_valid, 0);
        wait_idle_bus();
        get_rsp("after_drain", 32'h0, 1'b0);
        check("after_drain_sel", sel_cnt, snap + 1);

        // Response backpressure: second command waits for the slot.
        snap = sel_cnt;
        push(8'h51, 4'b0000, 32'h3);
        push(8'h52, 4'b0000, 32'h4);
        wait_rsp(lat);
        repeat (20) @(negedge clk);
        check("bp_one_issued", sel_cnt, snap + 1);
        check("bp_rsp_held", rsp_valid, 1);
        check("bp_one_queued", fifo_cnt, 1);
        get_rsp("bp_first", 32'h0, 1'b0);
        get_rsp("bp_second", 32'h0, 1'b0);
        check("bp_two_issued", sel_cnt, snap + 2);

        // Reset in WAIT_DONE with two commands queued.
        busy_len = 60;
        push(8'h61, 4'b0000, 32'h6);
        push(8'h62, 4'b0000, 32'h7);
        push(8'h63, 4'b0000, 32'h8);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_fifo_cnt", fifo_cnt, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_error", rsp_error, 0);
        check("mid_rst_m_sel", m_sel, 0);
        check("mid_rst_m_addr", m_addr, 0);
        check("mid_rst_m_data", m_data_out, 0);
        check("mid_rst_m_cmd", m_cmd, 0);
        snap = sel_cnt;
        push(8'h64, 4'b0000, 32'h9);
        repeat (10) @(negedge clk);
        check("post_rst_wait_busy", sel_cnt, snap);
        wait_idle_bus();
        get_rsp("post_rst", 32'h0, 1'b0);
        check("post_rst_one_issue", sel_cnt, snap + 1);
        repeat (5) @(negedge clk);
        check("post_rst_no_extra_rsp", rsp_valid, 0);
        check("post_rst_fifo_empty", fifo_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
